freq_meter_autorange: RTL and testbench
=======================================

# freq_meter_autorange

Parametrised, auto-ranging frequency meter for the 7-segment display top level. It counts rising edges of an asynchronous input over a fixed gate window, directly in BCD. Ranging is manual or automatic between direct counting and ÷10 prescaled counting. The latched result is shown on a multiplexed DIGITS-wide active-low seven-segment display, with leading-zero blanking and an overflow indication.

## Interface
- `GATE_CYCLES`, 100_000_000: gate window length in sysclk cycles (1 s at 100 MHz).
- `DIGITS`, 4: BCD digits counted and displayed, ≥2.
- `SCAN_CYCLES`, 100_000: sysclk cycles each digit stays selected.
- `sysclk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sigin`  in  1  measured signal, asynchronous to sysclk.
- `mode`  in  2  range mode: 00 manual direct, 01 manual ÷10, 1x auto.
- `highfreq`  out  1  1 = displayed value is in ÷10 range (multiply by 10).
- `ovf`  out  1  latched result saturated (display shows dashes).
- `valid`  out  1  one-cycle pulse when a new result is latched.
- `cathodes`  out  7  active-low segments, bit0=a … bit6=g.
- `an`  out  DIGITS  active-low digit enables, bit0 = least significant (rightmost).

## Operation
- Input path: 2-flop synchroniser on sigin, then a rising-edge detector. Output is a 1-cycle `edge` pulse, 3 cycles after the sigin transition.
- Prescaler: mod-10 counter of `edge` pulses; emits `tick` on the 9→0 wrap. Cleared at every gate start.
- Count source: `edge` when range=direct, `tick` when range=÷10.
- BCD counter: DIGITS decade digits, ripple-carry within one cycle. If every digit is 9 and an increment arrives, the counter holds 9…9 and sets the internal `sat`.
- Gate FSM, states RUN and LATCH:
  - RUN: gate counter counts 0…GATE_CYCLES-1. The count event in the final RUN cycle is included. Then go to LATCH.
  - LATCH, one cycle:
    - Copy BCD to the display register, `sat`→ovf, range→highfreq; pulse valid.
    - Clear the BCD counter, `sat`, the prescaler and the gate counter.
    - Apply the auto-range decision. Return to RUN.
  - Count events arriving in the LATCH cycle are dropped.
- Auto-range (mode=1x), evaluated in LATCH on the just-finished result:
  - Direct and sat=1 → ÷10 for the next gate.
  - ÷10, top digit = 0 and second digit ≤ 8 → direct for the next gate (hysteresis band).
  - Otherwise the range is unchanged.
- Manual modes force the range to direct (00) or ÷10 (01).
- Mode change: `mode` is registered. Any change versus the registered value restarts the gate immediately: FSM to RUN, counters cleared. The display, highfreq and ovf keep their last latched values; no valid pulse. Entering auto keeps the current range.
- Display scan:
  - Scan counter 0…SCAN_CYCLES-1. On wrap, the digit index advances 0→DIGITS-1→0.
  - `an` = ~(1<<index).
  - Segment decode, active low:
    - 0–9 standard patterns.
    - Blank (7'h7F) for leading zeros at index ≥1.
    - When ovf=1, all digits show '-' (7'b0111111).

## Timing
- Reset (asserted, async): highfreq=0, ovf=0, valid=0, an=all 1, cathodes=7'h7F. Range=direct, FSM=RUN with counters 0, display register 0, scan index 0.
- First cycle after rst falls: an=~1, cathodes=7'b1000000 ('0'). Other digits are blanked as leading zeros.
- Gate period is GATE_CYCLES+1 cycles, RUN plus LATCH. The first valid pulse comes GATE_CYCLES+1 cycles after reset release.
- Outputs are registered. valid, ovf, highfreq and the display update in the same cycle, the one after LATCH.
- Reset mid-gate: all state returns to reset values at once; the partial count is discarded.
- Input edges closer than 2 sysclk periods are not guaranteed to be counted. Maximum counted input is sysclk/2.

## Test plan
All cases use GATE_CYCLES=1000, SCAN_CYCLES=4, DIGITS=4 unless noted.
- Reset: hold rst 5 cycles, then release → during reset an=4'b1111 and cathodes=7'h7F; after release an=4'b1110 and cathodes=7'b1000000; valid first pulses 1001 cycles after release.
- Manual direct: mode=00, sigin period 10 cycles → the latched result is 0100 with highfreq=0. The scan shows '1','0','0' on digits 2..0, with digit 3 blank.
- Manual ÷10: mode=01, sigin period 2 cycles (500 edges) → the latched result is 0050 with highfreq=1 and ovf=0.
- Auto up, DIGITS=2: mode=10, sigin period 4 (250 edges) → the first result saturates: 99, ovf=1, all '-'. The next result is 25 with highfreq=1 and ovf=0.
- Auto down, DIGITS=2: continue with sigin period 100 (10 edges) → a ÷10 result of 01 → the next result is 10 with highfreq=0.
- Mode change mid-gate: switch 00→01 at gate cycle 500 → no valid pulse at the old boundary. The next valid comes 1001 cycles after the change, and the display holds its previous value until then.

Source files
------------

// File: rtl/freq_meter_autorange.sv
// freq_meter_autorange
//   Auto-ranging BCD frequency meter driving a multiplexed seven-segment display.
//   Rising edges of sigin are counted over a gate of GATE_CYCLES sysclk cycles,
//   either directly or through a divide-by-10 prescaler, and the latched result
//   is scanned onto DIGITS active-low digits with leading-zero blanking.
//
// Ports
//   sysclk    in   sole clock, rising edge
//   rst       in   asynchronous active-high reset
//   sigin     in   measured signal, asynchronous to sysclk
//   mode      in   00 manual direct, 01 manual /10, 1x auto-range
//   highfreq  out  displayed value is in the /10 range
//   ovf       out  displayed value saturated (dashes shown)
//   valid     out  one-cycle pulse when a new result is latched
//   cathodes  out  active-low segments, bit0 = a ... bit6 = g
//   an        out  active-low digit enables, bit0 = rightmost digit
//
// Gate FSM
//   state | meaning
//   RUN   | gate open, counting events, gate counter 0..GATE_CYCLES-1
//   LATCH | one cycle: publish result, clear counters, apply auto-range

module freq_meter_autorange #(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int DIGITS      = 4,
  parameter int SCAN_CYCLES = 100_000
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              sigin,
  input  logic [1:0]        mode,
  output logic              highfreq,
  output logic              ovf,
  output logic              valid,
  output logic [6:0]        cathodes,
  output logic [DIGITS-1:0] an
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int BW = 4 * DIGITS;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] LATCH = 1'b1;

  localparam logic [DIGITS-1:0] AN_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

  logic          sync1, sync2, sync3, edge_p;
  logic [3:0]    psc;
  logic          range_div;
  logic [1:0]    mode_r;
  logic [0:0]    state;
  logic [GW-1:0] gcnt;
  logic [BW-1:0] bcd, bcd_nxt, disp, disp_src;
  logic          sat, all9, carry;
  logic [SW-1:0] scnt;
  logic [IW-1:0] idx;

  logic          mode_chg, latch_now, tick, inc, ovf_src, zero_above;
  logic [3:0]    cur_digit;
  logic [DIGITS-1:0] blank;
  logic [6:0]    seg_nxt;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = 7'h7F;
    endcase
  endfunction

  // two-flop synchroniser plus registered rising-edge detect
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      edge_p <= 1'b0;
    end else begin
      sync1  <= sigin;
      sync2  <= sync1;
      sync3  <= sync2;
      edge_p <= sync2 & ~sync3;
    end
  end

  assign mode_chg  = (mode != mode_r);
  assign latch_now = (state == LATCH) && !mode_chg;
  assign tick      = edge_p && (psc == 4'd9);
  assign inc       = (state == RUN) && (range_div ? tick : edge_p);

  // decade ripple increment; all9 marks the saturation case
  always_comb begin
    bcd_nxt = bcd;
    carry   = 1'b1;
    all9    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd9) all9 = 1'b0;
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_nxt[4*i +: 4] = 4'd0;
        end else begin
          bcd_nxt[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      mode_r    <= 2'b00;
      state     <= RUN;
      gcnt      <= '0;
      psc       <= 4'd0;
      bcd       <= '0;
      sat       <= 1'b0;
      range_div <= 1'b0;
      disp      <= '0;
      ovf       <= 1'b0;
      highfreq  <= 1'b0;
      valid     <= 1'b0;
    end else begin
      mode_r <= mode;
      valid  <= 1'b0;
      if (mode_chg) begin
        // restart the gate; published result stays as it was
        state <= RUN;
        gcnt  <= '0;
        psc   <= 4'd0;
        bcd   <= '0;
        sat   <= 1'b0;
        if (!mode[1]) range_div <= mode[0];
      end else if (state == LATCH) begin
        disp     <= bcd;
        ovf      <= sat;
        highfreq <= range_div;
        valid    <= 1'b1;
        state    <= RUN;
        gcnt     <= '0;
        psc      <= 4'd0;
        bcd      <= '0;
        sat      <= 1'b0;
        if (mode_r[1]) begin
          // step down only below 09 in the top two digits, leaving a hysteresis band
          if (!range_div && sat)
            range_div <= 1'b1;
          else if (range_div && (bcd[4*(DIGITS-1) +: 4] == 4'd0) && (bcd[4*(DIGITS-2) +: 4] <= 4'd8))
            range_div <= 1'b0;
        end
      end else begin
        if (edge_p) psc <= (psc == 4'd9) ? 4'd0 : psc + 4'd1;
        if (inc) begin
          if (all9) sat <= 1'b1;
          else      bcd <= bcd_nxt;
        end
        if (gcnt == GW'(GATE_CYCLES - 1)) state <= LATCH;
        else                              gcnt  <= gcnt + GW'(1);
      end
    end
  end

  // segments are fed from the value being latched this cycle so the display
  // changes together with valid/ovf/highfreq
  always_comb begin
    disp_src   = latch_now ? bcd : disp;
    ovf_src    = latch_now ? sat : ovf;
    zero_above = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (disp_src[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
    cur_digit = disp_src[4*int'(idx) +: 4];
    if (ovf_src)         seg_nxt = 7'b0111111;
    else if (blank[idx]) seg_nxt = 7'h7F;
    else                 seg_nxt = dec7(cur_digit);
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      scnt     <= '0;
      idx      <= '0;
      an       <= '1;
      cathodes <= 7'h7F;
    end else begin
      if (scnt == SW'(SCAN_CYCLES - 1)) begin
        scnt <= '0;
        idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        scnt <= scnt + SW'(1);
      end
      an       <= ~(AN_ONE << idx);
      cathodes <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_freq_meter_autorange.sv
// tb_freq_meter_autorange
//   Directed bench: one 4-digit meter for reset, manual ranges and mid-gate
//   mode change, one 2-digit meter for auto-ranging up and down.
//   GATE_CYCLES=1000, SCAN_CYCLES=4 on both.

module tb_freq_meter_autorange;

  logic       sysclk = 1'b0;
  logic       rst    = 1'b1;
  logic       sig4   = 1'b0;
  logic       sig2   = 1'b0;
  logic [1:0] mode4  = 2'b00;
  logic [1:0] mode2  = 2'b00;

  logic       highfreq4, ovf4, valid4;
  logic [6:0] cathodes4;
  logic [3:0] an4;
  logic       highfreq2, ovf2, valid2;
  logic [6:0] cathodes2;
  logic [1:0] an2;

  int half4 = 5;   // sigin half-period in sysclk cycles
  int half2 = 2;
  int ph4 = 0;
  int ph2 = 0;
  int cyc = 0;
  int vcnt4 = 0;
  int npass = 0;
  int ntotal = 0;
  int n, t0, v0;

  freq_meter_autorange #(.GATE_CYCLES(1000), .DIGITS(4), .SCAN_CYCLES(4)) u4 (
    .sysclk(sysclk), .rst(rst), .sigin(sig4), .mode(mode4),
    .highfreq(highfreq4), .ovf(ovf4), .valid(valid4),
    .cathodes(cathodes4), .an(an4)
  );

  freq_meter_autorange #(.GATE_CYCLES(1000), .DIGITS(2), .SCAN_CYCLES(4)) u2 (
    .sysclk(sysclk), .rst(rst), .sigin(sig2), .mode(mode2),
    .highfreq(highfreq2), .ovf(ovf2), .valid(valid2),
    .cathodes(cathodes2), .an(an2)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    cyc <= cyc + 1;
    if (valid4) vcnt4 <= vcnt4 + 1;
  end

  // sigin generators, toggling 1 time unit after the falling clock edge
  always begin
    @(negedge sysclk);
    #1;
    ph4 = ph4 + 1;
    if (ph4 >= half4) begin
      sig4 = ~sig4;
      ph4  = 0;
    end
  end

  always begin
    @(negedge sysclk);
    #1;
    ph2 = ph2 + 1;
    if (ph2 >= half2) begin
      sig2 = ~sig2;
      ph2  = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_valid4(output int waited);
    waited = 0;
    do begin
      @(posedge sysclk); #1;
      waited++;
    end while (valid4 !== 1'b1 && waited < 1200);
    chk("valid4_seen", valid4, 1);
  endtask

  task automatic wait_valid2(output int waited);
    waited = 0;
    do begin
      @(posedge sysclk); #1;
      waited++;
    end while (valid2 !== 1'b1 && waited < 1200);
    chk("valid2_seen", valid2, 1);
  endtask

  task automatic dig4(input int i, input logic [6:0] exp, input string tag);
    int k;
    logic [3:0] want;
    k = 0;
    want = ~(4'b0001 << i);
    do begin
      @(negedge sysclk);
      k++;
    end while (an4 !== want && k < 40);
    chk(tag, {an4, cathodes4}, {want, exp});
  endtask

  task automatic dig2(input int i, input logic [6:0] exp, input string tag);
    int k;
    logic [1:0] want;
    k = 0;
    want = ~(2'b01 << i);
    do begin
      @(negedge sysclk);
      k++;
    end while (an2 !== want && k < 40);
    chk(tag, {an2, cathodes2}, {want, exp});
  endtask

  initial begin
    // reset held for 5 cycles
    repeat (3) @(negedge sysclk);
    chk("rst_an4", an4, 4'hF);
    chk("rst_cath4", cathodes4, 7'h7F);
    chk("rst_flags4", {valid4, ovf4, highfreq4}, 3'b000);
    chk("rst_an2", an2, 2'b11);
    chk("rst_cath2", cathodes2, 7'h7F);
    repeat (2) @(negedge sysclk);
    rst = 1'b0;

    @(posedge sysclk); #1;
    chk("post_rst_an4", an4, 4'b1110);
    chk("post_rst_cath4", cathodes4, 7'b1000000);
    n = 1;
    while (valid4 !== 1'b1 && n < 1200) begin
      @(posedge sysclk); #1;
      n++;
    end
    chk("first_valid_latency", n, 1001);

    // manual direct, sigin period 10 -> 0100
    wait_valid4(n);
    chk("gate_period", n, 1001);
    chk("direct_flags", {ovf4, highfreq4}, 2'b00);
    dig4(0, 7'b1000000, "direct_d0");
    dig4(1, 7'b1000000, "direct_d1");
    dig4(2, 7'b1111001, "direct_d2");
    dig4(3, 7'h7F,      "direct_d3");

    // mode 00 -> 01 at gate cycle 500; old boundary must not produce valid
    wait_valid4(n);
    repeat (499) @(posedge sysclk);
    @(negedge sysclk);
    mode4 = 2'b01;
    v0 = vcnt4;
    @(posedge sysclk); #1;   // first edge sampling the new mode restarts the gate
    t0 = cyc;
    repeat (599) @(posedge sysclk);
    #1;
    chk("chg_no_old_valid", vcnt4, v0);
    chk("chg_hold_hf", highfreq4, 0);
    dig4(2, 7'b1111001, "chg_hold_d2");
    wait_valid4(n);
    chk("chg_latency", cyc - t0, 1001);
    chk("chg_flags", {ovf4, highfreq4}, 2'b01);
    // 100 edges / 10 -> 0010
    dig4(0, 7'b1000000, "div10_p10_d0");
    dig4(1, 7'b1111001, "div10_p10_d1");
    dig4(2, 7'h7F,      "div10_p10_d2");
    dig4(3, 7'h7F,      "div10_p10_d3");

    // manual /10, sigin period 2 -> 500 edges -> 0050
    @(negedge sysclk);
    half4 = 1;
    ph4   = 0;
    wait_valid4(n);
    wait_valid4(n);
    chk("div10_flags", {ovf4, highfreq4}, 2'b01);
    dig4(0, 7'b1000000, "div10_d0");
    dig4(1, 7'b0010010, "div10_d1");
    dig4(2, 7'h7F,      "div10_d2");
    dig4(3, 7'h7F,      "div10_d3");

    // auto on the 2-digit meter, sigin period 4 -> 250 edges
    @(negedge sysclk);
    mode2 = 2'b10;
    wait_valid2(n);
    chk("auto_sat_flags", {ovf2, highfreq2}, 2'b10);
    dig2(0, 7'b0111111, "auto_sat_d0");
    dig2(1, 7'b0111111, "auto_sat_d1");

    wait_valid2(n);
    // switch to period 100 at the start of the next gate: 10..11 edges -> 01
    half2 = 50;
    ph2   = 0;
    sig2  = 1'b0;
    chk("auto_up_flags", {ovf2, highfreq2}, 2'b01);
    dig2(0, 7'b0010010, "auto_up_d0");
    dig2(1, 7'b0100100, "auto_up_d1");

    wait_valid2(n);
    chk("auto_lo_flags", {ovf2, highfreq2}, 2'b01);
    dig2(0, 7'b1111001, "auto_lo_d0");
    dig2(1, 7'h7F,      "auto_lo_d1");

    wait_valid2(n);
    chk("auto_down_flags", {ovf2, highfreq2}, 2'b00);
    dig2(0, 7'b1000000, "auto_down_d0");
    dig2(1, 7'b1111001, "auto_down_d1");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
